// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-requester round-robin arbiter driving a registered 2:1 mux.
// The owner FSM (IDLE/OWN0/OWN1) picks the select. Each beat registers the owner's
// data word onto out and pulses out_valid. A hold counter caps consecutive beats
// at MAX_HOLD while the other side is waiting.
// Optional build macro: MUX2_ARB_FIXED_PRIO_EN makes requester 0 the fixed
// high-priority side. Ties go to OWN0, and only OWN1 is ever forced to hand over.
module mux2_rr_arbiter #(
    parameter int WIDTH    = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    // Last beat index before a forced hand-over. The counter saturates here.
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [3:0]         hold_cnt_q, hold_cnt_d;
    logic               last_q, last_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               sel_q, sel_d;

    // Owner-relative views, so the OWN0/OWN1 handling is written only once.
    logic               own_id_s;
    logic               own_req_s;
    logic               oth_req_s;
    logic [WIDTH-1:0]   own_data_s;
    state_t             oth_state_s;
    state_t             tie_state_s;
    logic               force_ok_s;

    // Map the current owner onto owner/other signals.
    always_comb begin
        own_id_s    = 1'b0;
        own_req_s   = req0;
        oth_req_s   = req1;
        own_data_s  = d0;
        oth_state_s = ST_OWN1;
        if (state_q == ST_OWN1) begin
            own_id_s    = 1'b1;
            own_req_s   = req1;
            oth_req_s   = req0;
            own_data_s  = d1;
            oth_state_s = ST_OWN0;
        end else begin
            own_id_s    = 1'b0;
            own_req_s   = req0;
            oth_req_s   = req1;
            own_data_s  = d0;
            oth_state_s = ST_OWN1;
        end
    end

`ifdef MUX2_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 wins ties and is never forced to hand over.
    always_comb begin
        tie_state_s = ST_OWN0;
        force_ok_s  = own_id_s;
    end
`else
    // Round robin: the tie goes to whoever did not have the last beat.
    always_comb begin
        tie_state_s = last_q ? ST_OWN0 : ST_OWN1;
        force_ok_s  = 1'b1;
    end
`endif

    // Next-state, beat and hold-counter logic.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        last_d      = last_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hold_cnt_d = 4'd0;
                if (req0 && req1) begin
                    state_d = tie_state_s;
                end else if (req0) begin
                    state_d = ST_OWN0;
                end else if (req1) begin
                    state_d = ST_OWN1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_req_s) begin
                    // The owner let go. Hand over directly, or fall back to idle.
                    hold_cnt_d = 4'd0;
                    state_d    = oth_req_s ? oth_state_s : ST_IDLE;
                end else begin
                    out_d       = own_data_s;
                    out_valid_d = 1'b1;
                    last_d      = own_id_s;
                    if (oth_req_s && force_ok_s && (hold_cnt_q == HOLD_LAST)) begin
                        state_d    = oth_state_s;
                        hold_cnt_d = 4'd0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = hold_cnt_q;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = 4'd0;
            end
        endcase
    end

    // Grant and select decode from the next state. In idle, sel keeps its last value.
    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        sel_d  = sel_q;
        case (state_d)
            ST_OWN0: begin
                gnt0_d = 1'b1;
                sel_d  = 1'b0;
            end
            ST_OWN1: begin
                gnt1_d = 1'b1;
                sel_d  = 1'b1;
            end
            default: begin
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
                sel_d  = sel_q;
            end
        endcase
    end

    // State and output registers with immediate clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= 4'd0;
            last_q      <= 1'b1;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            last_q      <= last_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            sel_q       <= sel_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign sel       = sel_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter. Two instances share the same inputs:
// dut_a uses MAX_HOLD=4 and dut_b uses MAX_HOLD=1. The model tracks the owner,
// the number of beats in the current turn and the last beat owner.
module tb_mux2_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [1:0] d0, d1;

    logic       gnt0_a, gnt1_a, sel_a, vld_a;
    logic [1:0] out_a;
    logic       gnt0_b, gnt1_b, sel_b, vld_b;
    logic [1:0] out_b;

    int n_checks;
    int n_fail;

    // Model state per instance: index 0 = MAX_HOLD 4, index 1 = MAX_HOLD 1.
    int         m_own   [2];   // -1 idle, 0 or 1 = owner
    int         m_beats [2];   // beats taken in the current turn
    int         m_last  [2];
    logic [1:0] m_out   [2];
    logic       m_vld   [2];
    logic       m_sel   [2];
    int         mh      [2];

    mux2_rr_arbiter #(.WIDTH(2), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .sel(sel_a), .out(out_a), .out_valid(vld_a)
    );

    mux2_rr_arbiter #(.WIDTH(2), .MAX_HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .sel(sel_b), .out(out_b), .out_valid(vld_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]   = -1;
            m_beats[k] = 0;
            m_last[k]  = 1;
            m_out[k]   = 2'b00;
            m_vld[k]   = 1'b0;
            m_sel[k]   = 1'b0;
        end
    endtask

    function automatic logic [5:0] exp_vec(input int k);
        return {(m_own[k] == 0), (m_own[k] == 1), m_sel[k], m_out[k], m_vld[k]};
    endfunction

    // Advance the model by one rising edge, using the inputs the DUT samples there.
    task automatic model_update();
        int  o;
        logic r_own, r_oth, fok;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_own[k] = -1; m_beats[k] = 0; m_last[k] = 1;
                m_out[k] = 2'b00; m_vld[k] = 1'b0; m_sel[k] = 1'b0;
            end else begin
                m_vld[k] = 1'b0;
                if (m_own[k] < 0) begin
                    m_beats[k] = 0;
                    if (req0 && req1) begin
`ifdef MUX2_ARB_FIXED_PRIO_EN
                        m_own[k] = 0;
`else
                        m_own[k] = (m_last[k] == 1) ? 0 : 1;
`endif
                    end else if (req0) m_own[k] = 0;
                    else if (req1) m_own[k] = 1;
                end else begin
                    o     = m_own[k];
                    r_own = (o == 1) ? req1 : req0;
                    r_oth = (o == 1) ? req0 : req1;
`ifdef MUX2_ARB_FIXED_PRIO_EN
                    fok = (o == 1);
`else
                    fok = 1'b1;
`endif
                    if (!r_own) begin
                        m_own[k]   = r_oth ? 1 - o : -1;
                        m_beats[k] = 0;
                    end else begin
                        m_out[k]  = (o == 1) ? d1 : d0;
                        m_vld[k]  = 1'b1;
                        m_last[k] = o;
                        if (r_oth && fok && (m_beats[k] >= mh[k] - 1)) begin
                            m_own[k]   = 1 - o;
                            m_beats[k] = 0;
                        end else begin
                            m_beats[k] = m_beats[k] + 1;
                        end
                    end
                end
                if (m_own[k] >= 0) m_sel[k] = (m_own[k] == 1);
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = 2'b00; d1 = 2'b00;
        model_reset();
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({gnt0_a, gnt1_a, sel_a, out_a, vld_a} !== 6'b000000) begin
                n_fail++;
                $display("FAIL reset_idle_a cycle %0d: got %b expected 000000", i, {gnt0_a, gnt1_a, sel_a, out_a, vld_a});
            end
            n_checks++;
            if ({gnt0_b, gnt1_b, sel_b, out_b, vld_b} !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL reset_idle_b cycle %0d: got %b expected %b", i, {gnt0_b, gnt1_b, sel_b, out_b, vld_b}, exp_vec(1));
            end
        end
    endtask

    task automatic test_single();
        req0 = 1'b1; d0 = 2'b10;
        step();
        n_checks++;
        if ({gnt0_a, gnt1_a, vld_a} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_grant: got gnt0,gnt1,vld=%b expected 100", {gnt0_a, gnt1_a, vld_a});
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if ({gnt0_a, out_a, vld_a} !== 4'b1101) begin
                n_fail++;
                $display("FAIL single_beat %0d: got gnt0,out,vld=%b expected 1101", i, {gnt0_a, out_a, vld_a});
            end
            n_checks++;
            if ({gnt0_b, gnt1_b, sel_b, out_b, vld_b} !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL single_b %0d: got %b expected %b", i, {gnt0_b, gnt1_b, sel_b, out_b, vld_b}, exp_vec(1));
            end
        end
        req0 = 1'b0;
        step();
        step();
    endtask

    task automatic test_tie();
        logic [1:0] seq_a [$];
        logic [1:0] seq_b [$];
        logic [1:0] want;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; d0 = 2'b01; d1 = 2'b11;
        for (int i = 0; i < 20; i++) begin
            step();
            if (vld_a) seq_a.push_back(out_a);
            if (vld_b) seq_b.push_back(out_b);
            n_checks++;
            if ({gnt0_a, gnt1_a, sel_a, out_a, vld_a} !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL tie_a cycle %0d: got %b expected %b", i, {gnt0_a, gnt1_a, sel_a, out_a, vld_a}, exp_vec(0));
            end
            n_checks++;
            if ((gnt0_a & gnt1_a) !== 1'b0) begin
                n_fail++;
                $display("FAIL tie_exclusive cycle %0d: gnt0=%b gnt1=%b", i, gnt0_a, gnt1_a);
            end
        end
`ifndef MUX2_ARB_FIXED_PRIO_EN
        // 19 contiguous beats expected on both instances.
        n_checks++;
        if (seq_a.size() != 19 || seq_b.size() != 19) begin
            n_fail++;
            $display("FAIL tie_beat_count: got %0d/%0d expected 19/19", seq_a.size(), seq_b.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                want = ((i / 4) % 2 == 0) ? 2'b01 : 2'b11;
                n_checks++;
                if (seq_a[i] !== want) begin
                    n_fail++;
                    $display("FAIL tie_pattern_hold4 beat %0d: got %b expected %b", i, seq_a[i], want);
                end
                want = (i % 2 == 0) ? 2'b01 : 2'b11;
                n_checks++;
                if (seq_b[i] !== want) begin
                    n_fail++;
                    $display("FAIL tie_pattern_hold1 beat %0d: got %b expected %b", i, seq_b[i], want);
                end
            end
        end
`endif
    endtask

    task automatic test_early_release();
        int beats_d1;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();
        rst = 1'b0;
        d0 = 2'b01; d1 = 2'b11;
        req1 = 1'b1;
        step();
        req0 = 1'b1;
        beats_d1 = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) req1 = 1'b0;
            step();
            if (vld_a && out_a == 2'b11) beats_d1++;
            n_checks++;
            if ({gnt0_a, gnt1_a, sel_a, out_a, vld_a} !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL early_release_a cycle %0d: got %b expected %b", i, {gnt0_a, gnt1_a, sel_a, out_a, vld_a}, exp_vec(0));
            end
            n_checks++;
            if ({gnt0_b, gnt1_b, sel_b, out_b, vld_b} !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL early_release_b cycle %0d: got %b expected %b", i, {gnt0_b, gnt1_b, sel_b, out_b, vld_b}, exp_vec(1));
            end
        end
        n_checks++;
        if (beats_d1 != 2 || gnt0_a !== 1'b1) begin
            n_fail++;
            $display("FAIL early_release_count: got beats=%0d gnt0=%b expected beats=2 gnt0=1", beats_d1, gnt0_a);
        end
    endtask

    task automatic test_async_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();
        rst = 1'b0;
        req1 = 1'b1; d1 = 2'b11;
        step();
        step();
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({gnt0_a, gnt1_a, sel_a, out_a, vld_a} !== 6'b000000) begin
            n_fail++;
            $display("FAIL async_reset_clear: got %b expected 000000", {gnt0_a, gnt1_a, sel_a, out_a, vld_a});
        end
        #1;
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        step();
        n_checks++;
        if ({gnt0_a, gnt1_a, sel_a} !== 3'b100) begin
            n_fail++;
            $display("FAIL async_reset_rearb: got gnt0,gnt1,sel=%b expected 100", {gnt0_a, gnt1_a, sel_a});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req0 = ($urandom_range(0, 9) < 7);
            req1 = ($urandom_range(0, 9) < 7);
            d0   = 2'($urandom);
            d1   = 2'($urandom);
            rst  = ($urandom_range(0, 99) == 0);
            step();
            n_checks++;
            if ({gnt0_a, gnt1_a, sel_a, out_a, vld_a} !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL random_a cycle %0d: got %b expected %b", i, {gnt0_a, gnt1_a, sel_a, out_a, vld_a}, exp_vec(0));
            end
            n_checks++;
            if ({gnt0_b, gnt1_b, sel_b, out_b, vld_b} !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL random_b cycle %0d: got %b expected %b", i, {gnt0_b, gnt1_b, sel_b, out_b, vld_b}, exp_vec(1));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mh[0]    = 4;
        mh[1]    = 1;
        test_reset();
        test_single();
        test_tie();
        test_early_release();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
